s_pl_dly_var: RTL and testbench

S_PL_DLY_VAR -- requirements
Module: s_pl_dly_var

---
 rtl/s_pl_dly_var.sv | 126 ++++++++++++
 tb/tb_s_pl_dly_var.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/s_pl_dly_var.sv
// Variable-length pipeline delay line built on a circular buffer.
// The output is valid once the line holds enough samples for the selected delay.
module s_pl_dly_var #(
    parameter int              SIZE    = 8,
    parameter int              MAXDLY  = 16,
    parameter int              DLYW    = 5,
    parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ien,
    input  logic [SIZE-1:0] idat,
    input  logic [DLYW-1:0] dly,
    input  logic            flush,
    output logic [SIZE-1:0] odat,
    output logic            ovld
);

    localparam int              PW     = (MAXDLY > 1) ? $clog2(MAXDLY) : 1;
    localparam logic [DLYW-1:0] MAXD_W = DLYW'(MAXDLY);
    localparam logic [PW-1:0]   LAST_P = PW'(MAXDLY - 1);
    localparam logic [PW-1:0]   MAXD_P = PW'(MAXDLY);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [SIZE-1:0] mem [MAXDLY];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   wptr_next;
    logic [PW-1:0]   dly_mod;
    logic [PW-1:0]   rd_idx;
    logic [DLYW-1:0] fcnt;
    logic [DLYW-1:0] dly_r;
    logic [DLYW-1:0] dly_e;
    logic            dly_chg;

    always_comb begin
        dly_e = dly;
        if (dly == '0) begin
            dly_e = DLYW'(1);
        end else if (dly > MAXD_W) begin
            dly_e = MAXD_W;
        end
    end

    assign dly_chg   = (dly_e != dly_r);
    assign wptr_next = (wptr == LAST_P) ? '0 : wptr + 1'b1;

    // A delay of MAXDLY points back at the slot about to be overwritten; the
    // modulo arithmetic wraps correctly even when MAXDLY overflows PW bits.
    always_comb begin
        dly_mod = (dly_r == MAXD_W) ? '0 : dly_r[PW-1:0];
        if (wptr >= dly_mod) begin
            rd_idx = wptr - dly_mod;
        end else begin
            rd_idx = wptr + MAXD_P - dly_mod;
        end
    end

    // RUN is entered once fcnt has counted dly_r samples; flush and delay
    // changes both restart the fill.
    always_comb begin
        state_next = state;
        if (flush || dly_chg) begin
            state_next = FILL;
        end else if (ien && (state == FILL) && ((fcnt + 1'b1) == dly_r)) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Storage is never reset; odat is gated to RST_VAL until the line is full.
    always_ff @(posedge clk) begin
        if (ien && !flush) begin
            mem[wptr] <= idat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            fcnt  <= '0;
            dly_r <= DLYW'(1);
            odat  <= RST_VAL;
            ovld  <= 1'b0;
        end else begin
            dly_r <= dly_e;
            if (flush) begin
                wptr <= '0;
                fcnt <= '0;
                odat <= RST_VAL;
                ovld <= 1'b0;
            end else begin
                if (ien) begin
                    wptr <= wptr_next;
                end
                if (dly_chg) begin
                    fcnt <= '0;
                    odat <= RST_VAL;
                    ovld <= 1'b0;
                end else if (ien) begin
                    if (state == RUN) begin
                        odat <= mem[rd_idx];
                        ovld <= 1'b1;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                        odat <= RST_VAL;
                        ovld <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_s_pl_dly_var.sv
// Randomized self-checking bench for s_pl_dly_var against a queue-based
// model of the accepted-sample history.
module tb_s_pl_dly_var;

    localparam int         SIZE   = 8;
    localparam int         MAXDLY = 16;
    localparam int         DLYW   = 5;
    localparam logic [7:0] RSTV   = 8'h5A;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ien;
    logic [SIZE-1:0] idat;
    logic [DLYW-1:0] dly;
    logic            flush;
    logic [SIZE-1:0] odat;
    logic            ovld;

    int checks = 0;
    int errors = 0;

    // Model state: every accepted sample since the last flush/reset, the
    // number counted toward the current delay, and the registered delay.
    int         hist[$];
    int         cnt;
    int         dlyr;
    logic [7:0] m_odat;
    logic       m_ovld;

    s_pl_dly_var #(
        .SIZE   (SIZE),
        .MAXDLY (MAXDLY),
        .DLYW   (DLYW),
        .RST_VAL(RSTV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ien  (ien),
        .idat (idat),
        .dly  (dly),
        .flush(flush),
        .odat (odat),
        .ovld (ovld)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        hist.delete();
        cnt    = 0;
        dlyr   = 1;
        m_odat = RSTV;
        m_ovld = 1'b0;
    endtask

    // Drive one cycle of inputs (called at a falling edge), advance the model
    // through the coming rising edge, then compare at the next falling edge.
    task automatic applyStimulus(input logic i_ien, input logic [7:0] i_dat,
                                 input logic [DLYW-1:0] i_dly, input logic i_flush);
        int de;
        ien   = i_ien;
        idat  = i_dat;
        dly   = i_dly;
        flush = i_flush;
        de = (int'(i_dly) == 0) ? 1 : ((int'(i_dly) > MAXDLY) ? MAXDLY : int'(i_dly));
        if (i_flush) begin
            hist.delete();
            cnt    = 0;
            m_odat = RSTV;
            m_ovld = 1'b0;
        end else if (de != dlyr) begin
            if (i_ien) hist.push_back(int'(i_dat));
            cnt    = 0;
            m_odat = RSTV;
            m_ovld = 1'b0;
        end else if (i_ien) begin
            if (cnt == dlyr) begin
                m_odat = 8'(hist[hist.size() - dlyr]);
                m_ovld = 1'b1;
            end else begin
                cnt++;
                m_odat = RSTV;
                m_ovld = 1'b0;
            end
            hist.push_back(int'(i_dat));
            if (hist.size() > 64) void'(hist.pop_front());
        end
        dlyr = de;
        @(negedge clk);
        checkOutput("odat", int'(odat), int'(m_odat));
        checkOutput("ovld", int'(ovld), int'(m_ovld));
    endtask

    initial begin
        int         k;
        logic [4:0] cur_dly;
        logic [3:0] pat;
        rst_n = 1'b0;
        ien   = 1'b0;
        idat  = '0;
        dly   = 5'd3;
        flush = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_odat", int'(odat), int'(RSTV));
        checkOutput("reset_ovld", int'(ovld), 0);
        rst_n = 1'b1;

        // Continuous stream at delay 3: first valid output is sample 1 on clock 4
        repeat (2) applyStimulus(1'b0, 8'd0, 5'd3, 1'b0);
        for (k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 8'(k), 5'd3, 1'b0);
            if (k == 3) checkOutput("d3_not_yet", int'(ovld), 0);
            if (k == 4) begin
                checkOutput("d3_first_ovld", int'(ovld), 1);
                checkOutput("d3_first_odat", int'(odat), 1);
            end
        end

        // Delay 3 -> 5 while running, then refill
        applyStimulus(1'b1, 8'd11, 5'd5, 1'b0);
        checkOutput("chg_ovld_drop", int'(ovld), 0);
        checkOutput("chg_odat_rst", int'(odat), int'(RSTV));
        for (k = 12; k < 22; k++) applyStimulus(1'b1, 8'(k), 5'd5, 1'b0);

        // Flush with ien high while running
        applyStimulus(1'b1, 8'hEE, 5'd5, 1'b1);
        checkOutput("flush_ovld", int'(ovld), 0);
        for (k = 0; k < 8; k++) applyStimulus(1'b1, 8'(8'h30 + k), 5'd5, 1'b0);

        // Delay 4 with gapped enable pattern 1,0,1,1,0,1,1 (repeated)
        pat = 4'd0;
        for (k = 0; k < 21; k++) begin
            applyStimulus(((k % 7) != 1) && ((k % 7) != 4), 8'(8'hA0 + k), 5'd4, 1'b0);
        end

        // Maximum delay, wrap and read-before-write; then clamp cases
        for (k = 0; k < 40; k++) applyStimulus(1'b1, 8'($urandom), 5'd16, 1'b0);
        for (k = 0; k < 8; k++)  applyStimulus(1'b1, 8'($urandom), 5'd0, 1'b0);
        for (k = 0; k < 24; k++) applyStimulus(1'b1, 8'($urandom), 5'd20, 1'b0);

        // Asynchronous reset between edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_odat", int'(odat), int'(RSTV));
        checkOutput("async_rst_ovld", int'(ovld), 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (k = 0; k < 12; k++) applyStimulus(1'b1, 8'($urandom), 5'd2, 1'b0);

        // Random traffic with occasional delay changes and flushes
        cur_dly = 5'($urandom_range(0, 31));
        for (k = 0; k < 600; k++) begin
            if ($urandom_range(0, 39) == 0) cur_dly = 5'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), cur_dly,
                          $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
